read_controller_sdram: RTL and testbench
========================================

READ_CONTROLLER_SDRAM -- requirements
Module: read_controller_sdram

Interface
REQ-001 Parameter FrameWidth, default 640, pixels per line.
REQ-002 Parameter FrameHeight, default 480, lines per frame.
REQ-003 Parameter BurstLengthSDRAM, default 8, pixels per SDRAM read burst; power of two.
REQ-004 Parameter PixelBitWidth, default 16, bits per pixel.
REQ-005 Parameter AddressWidthSDRAM, default 24, SDRAM address width.
REQ-006 Parameter FifoDepth, default 32, pixel FIFO entries; power of two, at least 2*BurstLengthSDRAM.
REQ-007 CLK  input  1  single clock; all logic on rising edge.
REQ-008 RST  input  1  synchronous, active-high reset.
REQ-009 i_busy_wr  input  1  SDRAM writer busy; no new read burst starts while high.
REQ-010 i_sdram_valid_rd  input  1  SDRAM read word valid this cycle.
REQ-011 i_sdram_pixel  input  PixelBitWidth  SDRAM read data.
REQ-012 i_pixel_req  input  1  display consumer pops one pixel.
REQ-013 i_frame_start  input  1  one-cycle pulse; restart reading at frame address 0.
REQ-014 o_sdram_rd_req  output  1  one-cycle read-burst request.
REQ-015 o_sdram_addr  output  AddressWidthSDRAM  burst start address; valid with o_sdram_rd_req.
REQ-016 o_pixel  output  PixelBitWidth  pixel to display.
REQ-017 o_pixel_valid  output  1  o_pixel holds a popped pixel.
REQ-018 o_underrun  output  1  one-cycle pulse; pop requested while FIFO empty.
REQ-019 o_busy_rd  output  1  high whenever FSM not in IDLE.

Function
REQ-020 FSM states: IDLE, REQ, RECEIVE, DONE; 2-bit encoding.
REQ-021 IDLE->REQ when free FIFO slots >= BurstLengthSDRAM, i_busy_wr low, no frame restart pending, i_frame_start low.
REQ-022 REQ: o_sdram_rd_req=1 and o_sdram_addr=ReadAddr for exactly one cycle; burst counter cleared; next state RECEIVE.
REQ-023 RECEIVE: each cycle with i_sdram_valid_rd high, i_sdram_pixel written to FIFO tail and burst counter incremented; after the BurstLengthSDRAM-th word -> DONE.
REQ-024 DONE: ReadAddr += BurstLengthSDRAM; if result equals FrameWidth*FrameHeight, ReadAddr = 0; next state IDLE.
REQ-025 Free-slot check guarantees no FIFO overflow; writes while FIFO full are impossible by construction and are not guarded.
REQ-026 Pop: i_pixel_req high and FIFO non-empty -> next cycle o_pixel = FIFO head, o_pixel_valid = 1, head advances; latency one cycle.
REQ-027 i_pixel_req high and FIFO empty -> next cycle o_pixel_valid = 0, o_pixel = 0, o_underrun = 1 for one cycle.
REQ-028 i_pixel_req low -> next cycle o_pixel_valid = 0, o_pixel holds.
REQ-029 Same-cycle push and pop: occupancy unchanged; pop returns previous head, never the word being pushed into an empty FIFO.
REQ-030 FIFO pointers wrap modulo FifoDepth; occupancy counter is clog2(FifoDepth)+1 bits.
REQ-031 i_frame_start in IDLE: next cycle FIFO flushed (occupancy 0), ReadAddr = 0, no request issued that cycle.
REQ-032 i_frame_start in REQ/RECEIVE/DONE: restart-pending flag set; remaining burst words counted but not written to FIFO; on DONE, ReadAddr = 0, FIFO flushed, flag cleared.
REQ-033 i_frame_start coincident with i_pixel_req: flush takes priority; o_pixel_valid = 0 next cycle, no underrun pulse.
REQ-034 o_busy_rd registered: equals (state != IDLE) of previous cycle.

Reset
REQ-035 RST high at a rising edge: state IDLE, ReadAddr 0, FIFO empty, burst counter 0, pending flag 0.
REQ-036 Output reset values: o_sdram_rd_req 0, o_sdram_addr 0, o_pixel 0, o_pixel_valid 0, o_underrun 0, o_busy_rd 0.
REQ-037 RST mid-burst abandons the burst; later i_sdram_valid_rd words are ignored until a new REQ.

Verification
REQ-038 Reset release, i_busy_wr=0, valid words 0x0001..0x0008 -> o_sdram_rd_req pulse with addr 0, FIFO occupancy 8; second request addr 8.
REQ-039 i_busy_wr=1 held 20 cycles with FIFO empty -> o_sdram_rd_req stays 0; drop i_busy_wr -> request at addr 0 within 2 cycles.
REQ-040 Fill FIFO to 32 -> no request issued; pop 8 -> exactly one request; pops return 0x0001.. in order, o_pixel_valid one cycle after each i_pixel_req.
REQ-041 Frame of 640x480 with BurstLengthSDRAM 8 -> 38400 bursts, last address 307192, next address 0.
REQ-042 i_pixel_req on empty FIFO -> o_underrun=1 one cycle, o_pixel_valid=0, o_pixel=0.
REQ-043 i_frame_start after 3rd word of burst at addr 64 -> remaining 5 words dropped, FIFO empty after DONE, next request addr 0.

Source files
------------

// File: rtl/read_controller_sdram_if.sv
// Bundle of the SDRAM-read and pixel-consumer signals of the frame read controller.
// Latency: none; this only groups wires.
// Backpressure: the controller throttles itself through i_busy_wr and the FIFO free-slot count.
interface read_controller_sdram_if #(
  parameter int PixelBitWidth     = 16,
  parameter int AddressWidthSDRAM = 24
);
  logic                         i_busy_wr;
  logic                         i_sdram_valid_rd;
  logic [PixelBitWidth-1:0]     i_sdram_pixel;
  logic                         i_pixel_req;
  logic                         i_frame_start;
  logic                         o_sdram_rd_req;
  logic [AddressWidthSDRAM-1:0] o_sdram_addr;
  logic [PixelBitWidth-1:0]     o_pixel;
  logic                         o_pixel_valid;
  logic                         o_underrun;
  logic                         o_busy_rd;

  // Controller side.
  modport master (
    input  i_busy_wr, i_sdram_valid_rd, i_sdram_pixel, i_pixel_req, i_frame_start,
    output o_sdram_rd_req, o_sdram_addr, o_pixel, o_pixel_valid, o_underrun, o_busy_rd
  );

  // SDRAM / display side.
  modport slave (
    output i_busy_wr, i_sdram_valid_rd, i_sdram_pixel, i_pixel_req, i_frame_start,
    input  o_sdram_rd_req, o_sdram_addr, o_pixel, o_pixel_valid, o_underrun, o_busy_rd
  );
endinterface

// File: rtl/read_controller_sdram.sv
// Streams a frame from SDRAM in fixed bursts into a pixel FIFO feeding the display.
// Latency: pixel pop returns data one cycle after i_pixel_req; burst request is one cycle after IDLE decides.
// Backpressure: bursts start only with a whole burst of free FIFO slots and i_busy_wr low; empty pops flag underrun.
module read_controller_sdram #(
  parameter int FrameWidth        = 640,
  parameter int FrameHeight       = 480,
  parameter int BurstLengthSDRAM  = 8,
  parameter int PixelBitWidth     = 16,
  parameter int AddressWidthSDRAM = 24,
  parameter int FifoDepth         = 32
) (
  input logic CLK,
  input logic RST,
  read_controller_sdram_if.master bus
);

  localparam int FrameSize = FrameWidth * FrameHeight;
  localparam int PtrW      = $clog2(FifoDepth);
  localparam int CntW      = PtrW + 1;
  localparam int BcW       = $clog2(BurstLengthSDRAM) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RECEIVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                       state;
  logic [AddressWidthSDRAM-1:0] read_addr;
  logic [BcW-1:0]               burst_cnt;
  logic                         restart_pending;

  logic [PixelBitWidth-1:0]     mem [FifoDepth];
  logic [PtrW-1:0]              head;
  logic [PtrW-1:0]              tail;
  logic [CntW-1:0]              count;

  logic [CntW-1:0]              free_slots;
  logic                         can_start;
  logic                         restart_now;
  logic                         flush;
  logic                         push;
  logic                         pop;
  logic                         last_word;
  logic [AddressWidthSDRAM-1:0] next_addr;

  assign free_slots  = CntW'(FifoDepth) - count;
  assign can_start   = (free_slots >= CntW'(BurstLengthSDRAM)) && !bus.i_busy_wr
                       && !restart_pending && !bus.i_frame_start;
  // A restart seen in the DONE cycle itself is honoured at once rather than one burst later.
  assign restart_now = restart_pending || bus.i_frame_start;
  assign flush       = ((state == IDLE) && bus.i_frame_start) || ((state == DONE) && restart_now);
  // Words of a burst that straddles a frame restart belong to the old frame and are discarded.
  assign push        = (state == RECEIVE) && bus.i_sdram_valid_rd && !restart_now;
  // Pops only look at stored entries, so a word arriving into an empty FIFO is never bypassed.
  assign pop         = bus.i_pixel_req && (count != '0) && !flush;
  assign last_word   = (burst_cnt == BcW'(BurstLengthSDRAM - 1));
  assign next_addr   = read_addr + AddressWidthSDRAM'(BurstLengthSDRAM);

  // Burst sequencing FSM with registered request/address/busy outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state              <= IDLE;
      read_addr          <= '0;
      burst_cnt          <= '0;
      restart_pending    <= 1'b0;
      bus.o_sdram_rd_req <= 1'b0;
      bus.o_sdram_addr   <= '0;
      bus.o_busy_rd      <= 1'b0;
    end else begin
      bus.o_busy_rd      <= (state != IDLE);
      bus.o_sdram_rd_req <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_frame_start) begin
            read_addr <= '0;
          end else if (can_start) begin
            state              <= REQ;
            bus.o_sdram_rd_req <= 1'b1;
            bus.o_sdram_addr   <= read_addr;
          end
        end
        REQ: begin
          burst_cnt <= '0;
          state     <= RECEIVE;
          if (bus.i_frame_start) restart_pending <= 1'b1;
        end
        RECEIVE: begin
          if (bus.i_frame_start) restart_pending <= 1'b1;
          if (bus.i_sdram_valid_rd) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (last_word) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          if (restart_now) begin
            read_addr       <= '0;
            restart_pending <= 1'b0;
          end else if (next_addr == AddressWidthSDRAM'(FrameSize)) begin
            read_addr <= '0;
          end else begin
            read_addr <= next_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push) mem[tail] <= bus.i_sdram_pixel;
  end

  // FIFO pointers, occupancy and the registered pixel/underrun outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      bus.o_pixel       <= '0;
      bus.o_pixel_valid <= 1'b0;
      bus.o_underrun    <= 1'b0;
    end else begin
      bus.o_pixel_valid <= 1'b0;
      bus.o_underrun    <= 1'b0;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop) begin
          bus.o_pixel       <= mem[head];
          bus.o_pixel_valid <= 1'b1;
          head              <= head + 1'b1;
        end else if (bus.i_pixel_req) begin
          bus.o_pixel    <= '0;
          bus.o_underrun <= 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_read_controller_sdram.sv
// Directed bench for read_controller_sdram: vector table for the first burst, hand sequences for the rest.
// Latency: outputs are sampled 1 ns after each rising edge.
// Backpressure: the bench plays the SDRAM, serving each requested burst with eight valid words.
module tb_read_controller_sdram;

  localparam int FW = 32;
  localparam int FH = 4;
  localparam int BL = 8;
  localparam int PW = 16;
  localparam int AW = 24;
  localparam int FD = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  read_controller_sdram_if #(.PixelBitWidth(PW), .AddressWidthSDRAM(AW)) bus ();

  read_controller_sdram #(
    .FrameWidth(FW), .FrameHeight(FH), .BurstLengthSDRAM(BL),
    .PixelBitWidth(PW), .AddressWidthSDRAM(AW), .FifoDepth(FD)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic          busy_wr;
    logic          valid;
    logic [PW-1:0] pix;
    logic          req;
    logic          fs;
    logic          exp_rd;
    logic [AW-1:0] exp_addr;
    logic          exp_pv;
    logic [PW-1:0] exp_pix;
    logic          exp_un;
    logic          exp_busy;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl [12];

  function automatic vec_t mk(logic v, logic [PW-1:0] p, logic rd, logic [AW-1:0] ad, logic bz);
    vec_t t;
    t.busy_wr = 1'b0; t.valid = v; t.pix = p; t.req = 1'b0; t.fs = 1'b0;
    t.exp_rd = rd; t.exp_addr = ad; t.exp_pv = 1'b0; t.exp_pix = '0; t.exp_un = 1'b0; t.exp_busy = bz;
    return t;
  endfunction

  function automatic logic [43:0] outs();
    return {bus.o_sdram_rd_req, bus.o_sdram_addr, bus.o_pixel_valid, bus.o_pixel,
            bus.o_underrun, bus.o_busy_rd};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic words(logic [PW-1:0] base);
    for (int i = 0; i < BL; i++) begin
      bus.i_sdram_valid_rd = 1'b1;
      bus.i_sdram_pixel    = PW'(base + PW'(i));
      tick();
    end
    bus.i_sdram_valid_rd = 1'b0;
    bus.i_sdram_pixel    = '0;
  endtask

  // First tick is the REQ cycle, then the eight burst words.
  task automatic serve(logic [PW-1:0] base);
    bus.i_sdram_valid_rd = 1'b0;
    tick();
    words(base);
  endtask

  task automatic wait_req(string name, logic [AW-1:0] exp_addr, int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (bus.o_sdram_rd_req) seen = 1'b1;
    end
    check(name, 64'({seen, bus.o_sdram_addr}), 64'({1'b1, exp_addr}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;

    bus.i_busy_wr = 1'b0; bus.i_sdram_valid_rd = 1'b0; bus.i_sdram_pixel = '0;
    bus.i_pixel_req = 1'b0; bus.i_frame_start = 1'b0;

    tbl[0]  = mk(1'b0, 16'h0000, 1'b1, 24'd0, 1'b0);
    tbl[1]  = mk(1'b0, 16'h0000, 1'b0, 24'd0, 1'b1);
    for (int k = 1; k <= 8; k++) tbl[k+1] = mk(1'b1, 16'(k), 1'b0, 24'd0, 1'b1);
    tbl[10] = mk(1'b0, 16'h0000, 1'b0, 24'd0, 1'b1);
    tbl[11] = mk(1'b0, 16'h0000, 1'b1, 24'd8, 1'b0);

    RST = 1'b1;
    tick(); tick(); tick();
    check("reset_outputs", 64'(outs()), 64'd0);
    RST = 1'b0;

    // First burst from reset, then the second request at address 8.
    for (int s = 0; s < 12; s++) begin
      bus.i_busy_wr = tbl[s].busy_wr; bus.i_sdram_valid_rd = tbl[s].valid;
      bus.i_sdram_pixel = tbl[s].pix; bus.i_pixel_req = tbl[s].req; bus.i_frame_start = tbl[s].fs;
      tick();
      check($sformatf("vec_%0d", s), 64'(outs()),
            64'({tbl[s].exp_rd, tbl[s].exp_addr, tbl[s].exp_pv, tbl[s].exp_pix,
                 tbl[s].exp_un, tbl[s].exp_busy}));
    end
    bus.i_sdram_valid_rd = 1'b0;

    // Fill FIFO to 32 entries.
    serve(16'd9);
    wait_req("req_16", 24'd16, 6);
    serve(16'd17);
    wait_req("req_24", 24'd24, 6);
    serve(16'd25);
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (bus.o_sdram_rd_req) n++; end
    check("no_req_when_full", 64'(n), 64'd0);

    // Pop 8: data in order with one-cycle latency, then exactly one refill request.
    bus.i_pixel_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("pop_%0d", i), 64'({bus.o_pixel_valid, bus.o_pixel}), 64'({1'b1, 16'(i + 1)}));
    end
    bus.i_pixel_req = 1'b0;
    tick();
    check("refill_req_and_hold", 64'({bus.o_sdram_rd_req, bus.o_sdram_addr, bus.o_pixel_valid, bus.o_pixel}),
          64'({1'b1, 24'd32, 1'b0, 16'd8}));
    serve(16'd33);
    n = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (bus.o_sdram_rd_req) n++; end
    check("single_refill", 64'(n), 64'd0);

    // Drain with the writer busy, then underrun on the empty FIFO.
    bus.i_busy_wr = 1'b1;
    bus.i_pixel_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check($sformatf("drain_%0d", i), 64'({bus.o_pixel_valid, bus.o_pixel}), 64'({1'b1, 16'(i + 9)}));
    end
    tick();
    check("underrun", 64'({bus.o_underrun, bus.o_pixel_valid, bus.o_pixel}), 64'({1'b1, 1'b0, 16'd0}));
    bus.i_pixel_req = 1'b0;
    tick();
    check("underrun_one_cycle", 64'({bus.o_underrun, bus.o_pixel_valid}), 64'd0);

    // Reset again, hold writer busy, then release.
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    check("reset_again", 64'(outs()), 64'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (bus.o_sdram_rd_req) n++; end
    check("no_req_busy_wr", 64'(n), 64'd0);
    bus.i_busy_wr = 1'b0;
    wait_req("req_after_busy", 24'd0, 2);

    // Walk to the burst at 64 with the consumer popping.
    for (int a = 0; a < 64; a += 8) begin
      bus.i_pixel_req = (a < 56);
      serve(16'(16'h1000 + a));
      wait_req($sformatf("walk_req_%0d", a + 8), 24'(a + 8), 6);
    end

    // Frame restart after the third word of the burst at 64.
    bus.i_pixel_req = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.i_sdram_valid_rd = 1'b1; bus.i_sdram_pixel = 16'(16'h1040 + i); tick();
    end
    bus.i_sdram_valid_rd = 1'b0; bus.i_frame_start = 1'b1;
    tick();
    bus.i_frame_start = 1'b0;
    for (int i = 3; i < 8; i++) begin
      bus.i_sdram_valid_rd = 1'b1; bus.i_sdram_pixel = 16'(16'h1040 + i); tick();
    end
    bus.i_sdram_valid_rd = 1'b0;
    wait_req("req_after_restart", 24'd0, 6);
    bus.i_pixel_req = 1'b1;
    tick();
    check("flushed_empty", 64'({bus.o_underrun, bus.o_pixel_valid}), 64'({1'b1, 1'b0}));
    bus.i_pixel_req = 1'b0;
    words(16'h2000);
    bus.i_pixel_req = 1'b1;
    tick();
    check("first_after_restart", 64'({bus.o_pixel_valid, bus.o_pixel}), 64'({1'b1, 16'h2000}));
    wait_req("frame_req_8", 24'd8, 6);

    // Rest of the frame; the last burst is at 120 and the address wraps to 0.
    for (int a = 8; a < FW * FH; a += 8) begin
      serve(16'(16'h2000 + a));
      wait_req($sformatf("frame_req_%0d", (a + 8) % (FW * FH)), 24'((a + 8) % (FW * FH)), 6);
    end

    // Frame start coincident with a pop: flush wins, no pixel and no underrun.
    bus.i_pixel_req = 1'b0;
    serve(16'h3000);
    tick();
    bus.i_frame_start = 1'b1; bus.i_pixel_req = 1'b1;
    tick();
    check("flush_priority", 64'({bus.o_sdram_rd_req, bus.o_pixel_valid, bus.o_underrun}), 64'd0);
    bus.i_frame_start = 1'b0;
    tick();
    check("after_flush", 64'({bus.o_sdram_rd_req, bus.o_sdram_addr, bus.o_underrun, bus.o_pixel_valid}),
          64'({1'b1, 24'd0, 1'b1, 1'b0}));

    // Reset in the middle of a burst; later words must be ignored.
    bus.i_pixel_req = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.i_sdram_valid_rd = 1'b1; bus.i_sdram_pixel = 16'(16'h4000 + i); tick();
    end
    bus.i_sdram_valid_rd = 1'b0; bus.i_busy_wr = 1'b1; RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_mid_burst", 64'(outs()), 64'd0);
    for (int i = 3; i < 6; i++) begin
      bus.i_sdram_valid_rd = 1'b1; bus.i_sdram_pixel = 16'(16'h4000 + i); tick();
    end
    bus.i_sdram_valid_rd = 1'b0; bus.i_pixel_req = 1'b1;
    tick();
    check("ignored_after_rst", 64'({bus.o_sdram_rd_req, bus.o_underrun, bus.o_pixel_valid}),
          64'({1'b0, 1'b1, 1'b0}));
    bus.i_pixel_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
